cipo_combined_phase_selector: RTL and testbench
===============================================

// Module: cipo_combined_phase_selector
// PURPOSE
//  Recovers two 16-bit words (A, B) from a 4x-oversampled DDR CIPO bit vector.
//  - Uses a programmable sampling phase that compensates headstage cable delay.
//  - Sits between the CIPO oversampling shift capture and the CIPO data store in
//    data_generator_core; one instance per CIPO line.
//  - Registered output: one clock of latency.
// PARAMETERS
//  none (all widths fixed: 74-bit oversample window, 16-bit words, 4-bit phase)
// PORTS
//  clk           in   1   system clock; all state updates on rising edge
//  rstn          in   1   reset; asynchronous, active-low
//  phase_select  in   4   cable-delay phase p, in oversample ticks
//  CIPO4x        in   74  oversampled CIPO; bit n = sample taken n ticks after the first SCLK rise
//  CIPO          out  32  {B[15:0], A[15:0]}; A = rising-edge word, B = falling-edge (DDR) word
// BEHAVIOUR
//  - Reset: rstn low clears CIPO to 32'h0 immediately (async).
//    - CIPO holds 32'h0 until the first rising clk edge after rstn deasserts.
//  - Effective phase pe:
//    - pe = p when p <= 11.
//    - pe = 11 when p is 12..15 (saturate, so indices never exceed 73).
//  - Bit mapping, for k = 0..15, MSB first:
//    - A[15-k] = CIPO4x[4k + pe]
//    - B[15-k] = CIPO4x[4k + pe + 2]
//  - Highest index used: 60+11+2 = 73. Lowest index used: 0.
//  - Register update: on every rising clk edge, CIPO <= {B, A} computed from the
//    current phase_select and CIPO4x.
//    - No enable input.
//    - Latency is exactly 1 cycle from any input change to CIPO.
//  - phase_select may change on any cycle.
//    - The new phase applies at the next edge.
//    - No glitching or partial mixing of old and new phase in a registered value.
//  - Integration rule: the consumer must sample CIPO at least one clock after the
//    last CIPO4x bit is written.
//  - X on unused CIPO4x bits must not propagate to CIPO.
//  - No other state: no FSM, counters or handshakes.
// TESTING
//  1. Reset: rstn=0 with CIPO4x all ones -> CIPO=32'h0000_0000.
//     - Still 0 before the first edge after release.
//     - 32'hFFFF_FFFF one edge after release.
//  2. p=0, only CIPO4x[0] set -> CIPO=32'h0000_8000 one cycle later.
//     - Only bit 2 set -> 32'h8000_0000.
//     - Only bit 60 set -> 32'h0000_0001.
//     - Only bit 62 set -> 32'h0001_0000.
//  3. p=5, A=16'hA5A5 written at bits 4k+5 and B=16'h3C3C at bits 4k+7, all other bits
//     the inverse pattern -> CIPO=32'h3C3C_A5A5.
//  4. Saturation:
//     - p=11, only bit 73 set -> CIPO=32'h0001_0000.
//     - p=13 with the same vector -> same value.
//     - p=15 with only bit 11 set -> 32'h0000_8000.
//  5. Phase sweep: vector with A=16'h1234, B=16'hDEF0 at pe=3; hold the vector and step p
//     0..15 one per cycle.
//     - Exact match only when p=3.
//     - Every output equals the mapping formula, lagging p by one cycle.
//  6. Async reset mid-stream: assert rstn between edges while CIPO is nonzero
//     -> CIPO goes to 0 without waiting for clk.

Source files
------------

// File: rtl/cipo_combined_phase_selector.sv
// -----------------------------------------------------------------------------
// cipo_combined_phase_selector
//
// Recovers the two 16-bit DDR words carried on one CIPO line from its 4x
// oversampled capture window. A programmable phase offset compensates for
// headstage cable delay. The output is registered, so it appears one clock
// after the inputs.
//
// Ports:
//   clk           system clock, rising-edge active
//   rstn          asynchronous active-low reset, clears CIPO
//   phase_select  cable-delay phase in oversample ticks (12..15 saturate to 11)
//   CIPO4x        oversampled CIPO; bit n = sample n ticks after first SCLK rise
//   CIPO          {B, A}: A = rising-edge word, B = falling-edge word, MSB first
// -----------------------------------------------------------------------------
module cipo_combined_phase_selector (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  phase_select,
  input  logic [73:0] CIPO4x,
  output logic [31:0] CIPO
);

  logic [3:0]  pe;
  logic [6:0]  idx_a;
  logic [6:0]  idx_b;
  logic [31:0] cipo_d;
  logic [31:0] cipo_q;

  // Saturating the phase at 11 keeps the highest sampled index at 60+11+2 = 73.
  // Only the selected bits reach cipo_d, so X on unused samples cannot leak.
  always_comb begin
    pe     = (phase_select > 4'd11) ? 4'd11 : phase_select;
    cipo_d = '0;
    idx_a  = '0;
    idx_b  = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      idx_a = 7'(4 * k) + 7'(pe);
      idx_b = idx_a + 7'd2;
      cipo_d[5'(15 - k)] = CIPO4x[idx_a];
      cipo_d[5'(31 - k)] = CIPO4x[idx_b];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cipo_q <= '0;
    end else begin
      cipo_q <= cipo_d;
    end
  end

  assign CIPO = cipo_q;

endmodule

// File: tb/tb_cipo_combined_phase_selector.sv
// -----------------------------------------------------------------------------
// tb_cipo_combined_phase_selector
//
// Directed vector bench for cipo_combined_phase_selector: a table of single-
// cycle vectors plus hand-written sequences for reset, phase sweep and
// asynchronous reset while the output is live.
// -----------------------------------------------------------------------------
module tb_cipo_combined_phase_selector;

  logic        clk;
  logic        rstn;
  logic [3:0]  phase_select;
  logic [73:0] CIPO4x;
  logic [31:0] CIPO;

  int unsigned n_cmp;
  int unsigned n_fail;

  cipo_combined_phase_selector dut (
    .clk          (clk),
    .rstn         (rstn),
    .phase_select (phase_select),
    .CIPO4x       (CIPO4x),
    .CIPO         (CIPO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  p;
    logic [73:0] vec;
    logic [31:0] exp;
  } vec_t;

  localparam int unsigned NVEC = 10;
  vec_t tbl [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Place word a at bits 4k+pe and word b at bits 4k+pe+2, MSB at k=0.
  function automatic logic [73:0] place(input int unsigned pe, input logic [15:0] a,
                                        input logic [15:0] b, input logic [73:0] base);
    logic [73:0] v;
    v = base;
    for (int k = 0; k < 16; k++) begin
      v[4*k + pe]     = a[15-k];
      v[4*k + pe + 2] = b[15-k];
    end
    return v;
  endfunction

  // Reference recovery of {B, A} from a vector at phase p.
  function automatic logic [31:0] recover(input logic [73:0] v, input logic [3:0] p);
    int unsigned pe;
    logic [15:0] a;
    logic [15:0] b;
    pe = (p > 4'd11) ? 11 : int'(p);
    for (int k = 0; k < 16; k++) begin
      a[15-k] = v[4*k + pe];
      b[15-k] = v[4*k + pe + 2];
    end
    return {b, a};
  endfunction

  task automatic apply(input logic [3:0] p, input logic [73:0] v);
    @(negedge clk);
    phase_select = p;
    CIPO4x       = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [73:0] v;
    logic [73:0] sweep_vec;
    logic [31:0] prev_exp;
    logic [31:0] cur_exp;

    n_cmp  = 0;
    n_fail = 0;

    v = '0; v[0]  = 1'b1; tbl[0] = '{"p0_bit0",   4'd0,  v, 32'h0000_8000};
    v = '0; v[2]  = 1'b1; tbl[1] = '{"p0_bit2",   4'd0,  v, 32'h8000_0000};
    v = '0; v[60] = 1'b1; tbl[2] = '{"p0_bit60",  4'd0,  v, 32'h0000_0001};
    v = '0; v[62] = 1'b1; tbl[3] = '{"p0_bit62",  4'd0,  v, 32'h0001_0000};
    v = place(5, 16'hA5A5, 16'h3C3C, place(6, ~16'hA5A5, ~16'h3C3C, '1));
    tbl[4] = '{"p5_pattern", 4'd5, v, 32'h3C3C_A5A5};
    v = '0; v[73] = 1'b1; tbl[5] = '{"p11_bit73", 4'd11, v, 32'h0001_0000};
    v = '0; v[73] = 1'b1; tbl[6] = '{"p13_bit73", 4'd13, v, 32'h0001_0000};
    v = '0; v[11] = 1'b1; tbl[7] = '{"p15_bit11", 4'd15, v, 32'h0000_8000};
    v = '0; v[11] = 1'b1; tbl[8] = '{"p12_bit11", 4'd12, v, 32'h0000_8000};
    v = place(0, 16'hC3A1, 16'h5E7F, {74{1'bx}});
    tbl[9] = '{"p0_x_unused", 4'd0, v, 32'h5E7F_C3A1};

    // Reset with all-ones input must hold the output at zero.
    rstn         = 1'b0;
    phase_select = 4'd0;
    CIPO4x       = '1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", CIPO, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("reset_release_pre_edge", CIPO, 32'h0);
    @(posedge clk);
    #1;
    check("reset_first_edge", CIPO, 32'hFFFF_FFFF);

    for (int i = 0; i < NVEC; i++) begin
      apply(tbl[i].p, tbl[i].vec);
      check(tbl[i].name, CIPO, tbl[i].exp);
    end

    // Phase sweep: output follows p with one cycle of lag.
    sweep_vec = place(3, 16'h1234, 16'hDEF0, '0);
    apply(4'd0, sweep_vec);
    prev_exp = recover(sweep_vec, 4'd0);
    check("sweep_p0", CIPO, prev_exp);
    for (int p = 1; p < 16; p++) begin
      @(negedge clk);
      phase_select = 4'(p);
      #1;
      check("sweep_lag", CIPO, prev_exp);
      @(posedge clk);
      #1;
      cur_exp = recover(sweep_vec, 4'(p));
      check("sweep_formula", CIPO, cur_exp);
      check("sweep_exact", {31'd0, CIPO == 32'hDEF0_1234}, {31'd0, p == 3});
      prev_exp = cur_exp;
    end

    // Asynchronous reset between edges while the output is nonzero.
    apply(4'd5, tbl[4].vec);
    check("pre_async_reset", CIPO, 32'h3C3C_A5A5);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset", CIPO, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("post_async_reset", CIPO, 32'h3C3C_A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
